mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store engine: runs LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a req/ack data bus and stalls the pipe
//  until done. Sits between EX/MEM and MEM/WB registers; its LLbit_we_o/LLbit_value_o feed the LLbit register,
//  whose output returns here as LLbit_i. Big-endian lanes; non-memory ops pass through in 0 cycles.
// PARAMETERS
//  AW  32  bus/address width
//  DW  32  data width (fixed 32; lane logic assumes 4 bytes)
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   reset, asynchronous, active-low
//  flush             in   1   pipeline flush (exception/eret)
//  mem_op_i          in   4   op code (package constants; MOP_NONE=0)
//  mem_addr_i        in   AW  effective address
//  mem_wdata_i       in   DW  store data (rt)
//  wd_i / wreg_i     in   5/1 dest reg / write enable from EX/MEM
//  wdata_i           in   DW  ALU result (non-memory ops)
//  LLbit_i           in   1   committed LLbit
//  wb_LLbit_we_i     in   1   LLbit write pending in MEM/WB (forward)
//  wb_LLbit_value_i  in   1   its value
//  bus_req_o         out  1   bus request (registered)
//  bus_we_o          out  1   1=write (registered)
//  bus_addr_o        out  AW  word-aligned address {addr[31:2],2'b00} (registered)
//  bus_sel_o         out  4   byte lanes, bit3=byte0 (registered)
//  bus_wdata_o       out  DW  lane-replicated store data (registered)
//  bus_rdata_i       in   DW  read data, valid with ack
//  bus_ack_i         in   1   transfer complete
//  wd_o/wreg_o       out  5/1 dest reg / write enable to MEM/WB
//  wdata_o           out  DW  result to MEM/WB
//  LLbit_we_o        out  1   LLbit write enable
//  LLbit_value_o     out  1   LLbit value
//  stallreq_o        out  1   stall request to ctrl
//  excp_adel_o/ades_o out 1   misaligned load / store
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE; bus_req_o/bus_we_o=0, bus_addr_o/sel/wdata=0, rdata_q=0; all outputs 0.
//  - FSM: IDLE -> (aligned mem op needing bus) BUSY -> (bus_ack_i) DONE -> IDLE; BUSY -> (flush) ABORT ->
//    (bus_ack_i) IDLE. bus_req_o registered: set on IDLE->BUSY, held with addr/sel/we/wdata stable until ack.
//  - Ack may come in first req cycle; rdata captured into rdata_q on ack. Min load/store: 2 stall cycles,
//    result valid in DONE (stallreq_o=0 there).
//  - stallreq_o = bus op present && state!=DONE, or state==ABORT. Non-mem ops: pass wd/wreg/wdata, no stall.
//  - Alignment: H ops need addr[0]=0; W/LL/SC need addr[1:0]=0. Misaligned: no bus, no stall, excp_* =1,
//    wreg_o=0, LLbit_we_o=0.
//  - Lanes: byte n -> sel 4'b1000>>n, data[31-8n -: 8]; half at 0 -> 4'b1100, at 2 -> 4'b0011. LB/LH sign-,
//    LBU/LHU zero-extend; store data replicated to all lanes.
//  - LL: word load; in DONE LLbit_we_o=1, LLbit_value_o=1.
//  - SC: llbit_eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i. If 0: no bus, no stall, wreg_o=1, wdata_o=0,
//    LLbit_we_o=0. If 1: word store; in DONE wdata_o=1, LLbit_we_o=1, LLbit_value_o=0.
//  - flush in IDLE/DONE: next state IDLE, outputs that cycle zeroed. flush in BUSY: ABORT, wait ack, discard
//    data, no write-back, no LLbit write. flush in ABORT ignored. Held inputs while stalled are not resampled.
//  - rst low mid-transaction: immediate IDLE, bus_req_o drops asynchronously.
// STRUCTURE
//  - Package mips_mem_pkg: MOP_* op codes (NONE,LB,LBU,LH,LHU,LW,SB,SH,SW,LL,SC), state enum
//    {IDLE,BUSY,DONE,ABORT}, lane select constants.
//  - Sub-module mem_lane_align (combinational): sel/store replication and load extraction/extension.
// TESTING
//  - LW addr 0x100, ack 1st req cycle, rdata 0xDEADBEEF -> sel 4'hF, stall 2 cycles, wdata_o=0xDEADBEEF.
//  - LB addr 0x103, rdata 0x000000F0 -> sel 4'b0001, wdata_o=0xFFFFFFF0; LBU same -> 0x000000F0.
//  - LL 0x200 then SC 0x200 (wb forward LLbit=1, ack after 3 wait cycles) -> LLbit_we 1/val 1, then
//    bus write data replicated, wdata_o=1, LLbit_we 1/val 0.
//  - SC with LLbit_i=1 but wb_LLbit_we_i=1,value=0 -> no bus_req, stallreq_o=0, wdata_o=0.
//  - SH addr 0x101 -> excp_ades_o=1, bus_req_o stays 0, wreg_o=0.
//  - LW, flush in BUSY, ack 2 cycles later -> ABORT held, no wreg_o/LLbit_we_o, IDLE after ack; rst low mid-BUSY
//    -> bus_req_o=0 immediately.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM-stage load/store engine:
//   - MOP_* memory operation codes (MOP_NONE = 0 means "not a memory op")
//   - mem_state_e : engine FSM states
//   - SEL_* byte-lane select constants (bit 3 = byte 0, big-endian lanes)
//   - small op classification helpers
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam logic [3:0] MOP_NONE = 4'd0;
    localparam logic [3:0] MOP_LB   = 4'd1;
    localparam logic [3:0] MOP_LBU  = 4'd2;
    localparam logic [3:0] MOP_LH   = 4'd3;
    localparam logic [3:0] MOP_LHU  = 4'd4;
    localparam logic [3:0] MOP_LW   = 4'd5;
    localparam logic [3:0] MOP_SB   = 4'd6;
    localparam logic [3:0] MOP_SH   = 4'd7;
    localparam logic [3:0] MOP_SW   = 4'd8;
    localparam logic [3:0] MOP_LL   = 4'd9;
    localparam logic [3:0] MOP_SC   = 4'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } mem_state_e;

    localparam logic [3:0] SEL_NONE  = 4'b0000;
    localparam logic [3:0] SEL_BYTE0 = 4'b1000;
    localparam logic [3:0] SEL_HALF0 = 4'b1100;
    localparam logic [3:0] SEL_HALF2 = 4'b0011;
    localparam logic [3:0] SEL_WORD  = 4'b1111;

    // Any op that touches memory (including SC, which may still skip the bus).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MOP_LB) && (op <= MOP_SC);
    endfunction

    // Ops that write memory; SC counts as a store.
    function automatic logic is_store_op(input logic [3:0] op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SC);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for a 32-bit big-endian bus.
// Ports:
//   op_i       in  4   memory op code (MOP_*)
//   addr_lo_i  in  2   address bits [1:0]
//   st_data_i  in  32  store data (rt)
//   ld_data_i  in  32  raw bus read word
//   sel_o      out 4   byte lane select, bit3 = byte 0 (0 when misaligned)
//   st_data_o  out 32  store data replicated across all lanes
//   ld_data_o  out 32  extracted and sign/zero-extended load result
//   misalign_o out 1   address not aligned for the access size
// -----------------------------------------------------------------------------
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  sel_o,
    output logic [31:0] st_data_o,
    output logic [31:0] ld_data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/halfword out of the read word (byte 0 is MSB).
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_s = ld_data_i[31:24];
            2'd1:    byte_s = ld_data_i[23:16];
            2'd2:    byte_s = ld_data_i[15:8];
            2'd3:    byte_s = ld_data_i[7:0];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo_i[1]) begin
            half_s = ld_data_i[15:0];
        end else begin
            half_s = ld_data_i[31:16];
        end
    end

    // Lane select, store replication and alignment check per access size.
    always_comb begin
        sel_o      = SEL_NONE;
        st_data_o  = 32'h0000_0000;
        misalign_o = 1'b0;
        case (op_i)
            MOP_LB, MOP_LBU, MOP_SB: begin
                sel_o     = SEL_BYTE0 >> addr_lo_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            MOP_LH, MOP_LHU, MOP_SH: begin
                st_data_o = {2{st_data_i[15:0]}};
                if (addr_lo_i[0]) begin
                    misalign_o = 1'b1;
                end else if (addr_lo_i[1]) begin
                    sel_o = SEL_HALF2;
                end else begin
                    sel_o = SEL_HALF0;
                end
            end
            MOP_LW, MOP_SW, MOP_LL, MOP_SC: begin
                st_data_o = st_data_i;
                if (addr_lo_i != 2'b00) begin
                    misalign_o = 1'b1;
                end else begin
                    sel_o = SEL_WORD;
                end
            end
            default: sel_o = SEL_NONE;
        endcase
    end

    // Load result extension.
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (op_i)
            MOP_LB:         ld_data_o = {{24{byte_s[7]}}, byte_s};
            MOP_LBU:        ld_data_o = {24'h00_0000, byte_s};
            MOP_LH:         ld_data_o = {{16{half_s[15]}}, half_s};
            MOP_LHU:        ld_data_o = {16'h0000, half_s};
            MOP_LW, MOP_LL: ld_data_o = ld_data_i;
            default:        ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store engine. Runs LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a
// req/ack bus and holds the pipe with stallreq_o until the transfer is done.
// Non-memory ops pass through combinationally with no stall.
// Ports:
//   clk, rst (async, active-low), flush
//   mem_op_i/mem_addr_i/mem_wdata_i   op, effective address, store data
//   wd_i/wreg_i/wdata_i               EX/MEM destination, write enable, ALU result
//   LLbit_i, wb_LLbit_we_i/value_i    committed LLbit and MEM/WB forward
//   bus_req_o/we_o/addr_o/sel_o/wdata_o  registered bus request
//   bus_rdata_i/bus_ack_i             bus response
//   wd_o/wreg_o/wdata_o               to MEM/WB
//   LLbit_we_o/LLbit_value_o          LLbit register update
//   stallreq_o                        stall request
//   excp_adel_o/excp_ades_o           misaligned load / store
// -----------------------------------------------------------------------------
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [3:0]    mem_op_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    input  logic [4:0]    wd_i,
    input  logic          wreg_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          LLbit_i,
    input  logic          wb_LLbit_we_i,
    input  logic          wb_LLbit_value_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [3:0]    bus_sel_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i,
    output logic [4:0]    wd_o,
    output logic          wreg_o,
    output logic [DW-1:0] wdata_o,
    output logic          LLbit_we_o,
    output logic          LLbit_value_o,
    output logic          stallreq_o,
    output logic          excp_adel_o,
    output logic          excp_ades_o
);

    mem_state_e    state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]    bus_sel_q, bus_sel_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    // Op and low address bits latched at launch so the result is formed from
    // the transaction that actually ran, not from whatever sits on the inputs.
    logic [3:0]    op_q, op_d;
    logic [1:0]    addr_lo_q, addr_lo_d;

    logic          llbit_eff_s;
    logic [3:0]    align_op_s;
    logic [1:0]    align_addr_s;
    logic [3:0]    sel_s;
    logic [DW-1:0] st_rep_s;
    logic [DW-1:0] ld_ext_s;
    logic          misalign_s;

    // A pending LLbit write in MEM/WB is newer than the committed LLbit.
    assign llbit_eff_s = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;

    // In IDLE the lane logic looks at the incoming op; afterwards at the latched one.
    assign align_op_s   = (state_q == IDLE) ? mem_op_i        : op_q;
    assign align_addr_s = (state_q == IDLE) ? mem_addr_i[1:0] : addr_lo_q;

    mem_lane_align u_lane (
        .op_i       (align_op_s),
        .addr_lo_i  (align_addr_s),
        .st_data_i  (mem_wdata_i),
        .ld_data_i  (rdata_q),
        .sel_o      (sel_s),
        .st_data_o  (st_rep_s),
        .ld_data_o  (ld_ext_s),
        .misalign_o (misalign_s)
    );

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

    // State and bus request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            op_q        <= MOP_NONE;
            addr_lo_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            op_q        <= op_d;
            addr_lo_q   <= addr_lo_d;
        end
    end

    // Next-state, bus launch/retire and pipeline-facing outputs.
    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_sel_d     = bus_sel_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        op_d          = op_q;
        addr_lo_d     = addr_lo_q;
        wd_o          = 5'd0;
        wreg_o        = 1'b0;
        wdata_o       = '0;
        LLbit_we_o    = 1'b0;
        LLbit_value_o = 1'b0;
        stallreq_o    = 1'b0;
        excp_adel_o   = 1'b0;
        excp_ades_o   = 1'b0;

        if (!rst) begin
            // Held in reset: every output stays low.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_d = IDLE;
                    end else if (!is_mem_op(mem_op_i)) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misalign_s) begin
                        wd_o        = wd_i;
                        excp_ades_o = is_store_op(mem_op_i);
                        excp_adel_o = ~is_store_op(mem_op_i);
                    end else if ((mem_op_i == MOP_SC) && !llbit_eff_s) begin
                        // Failed SC: reports 0 without touching memory.
                        wd_o    = wd_i;
                        wreg_o  = 1'b1;
                        wdata_o = '0;
                    end else begin
                        wd_o        = wd_i;
                        stallreq_o  = 1'b1;
                        state_d     = BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = is_store_op(mem_op_i);
                        bus_addr_d  = {mem_addr_i[AW-1:2], 2'b00};
                        bus_sel_d   = sel_s;
                        bus_wdata_d = st_rep_s;
                        op_d        = mem_op_i;
                        addr_lo_d   = mem_addr_i[1:0];
                    end
                end
                BUSY: begin
                    wd_o       = wd_i;
                    stallreq_o = 1'b1;
                    if (bus_ack_i) begin
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = '0;
                        bus_sel_d   = 4'b0000;
                        bus_wdata_d = '0;
                        // A flush landing on the ack cycle simply drops the result.
                        if (flush) begin
                            state_d = IDLE;
                        end else begin
                            rdata_d = bus_rdata_i;
                            state_d = DONE;
                        end
                    end else if (flush) begin
                        state_d = ABORT;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    if (flush) begin
                        wd_o = 5'd0;
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = ld_ext_s;
                        if (op_q == MOP_LL) begin
                            LLbit_we_o    = 1'b1;
                            LLbit_value_o = 1'b1;
                        end else if (op_q == MOP_SC) begin
                            wreg_o        = 1'b1;
                            wdata_o       = {{(DW-1){1'b0}}, 1'b1};
                            LLbit_we_o    = 1'b1;
                            LLbit_value_o = 1'b0;
                        end else begin
                            LLbit_we_o = 1'b0;
                        end
                    end
                end
                ABORT: begin
                    // Bus cycle already issued must finish; its data is discarded.
                    stallreq_o = 1'b1;
                    if (bus_ack_i) begin
                        state_d     = IDLE;
                        bus_req_d   = 1'b0;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = '0;
                        bus_sel_d   = 4'b0000;
                        bus_wdata_d = '0;
                    end else begin
                        state_d = ABORT;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: each task drives one scenario and
// compares observed outputs to hand-computed values.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        LLbit_i;
    logic        wb_LLbit_we_i;
    logic        wb_LLbit_value_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        LLbit_we_o;
    logic        LLbit_value_o;
    logic        stallreq_o;
    logic        excp_adel_o;
    logic        excp_ades_o;

    int checks = 0;
    int errors = 0;

    // results of the last run_op
    int          r_stalls;
    logic        r_req;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_bwdata;
    logic [31:0] r_res;
    logic        r_wreg;
    logic        r_llwe;
    logic        r_llval;
    logic        r_adel;
    logic        r_ades;

    mem_access_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o),
        .stallreq_o(stallreq_o), .excp_adel_o(excp_adel_o), .excp_ades_o(excp_ades_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op at posedge+1 and plays the bus slave: ack after 'waits'
    // request cycles. Returns captured bus fields and the outputs seen in the
    // first non-stalled cycle. Stall loop is bounded.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] st, input logic [31:0] rd,
                          input int waits, input logic wr);
        int w;
        w = 0;
        r_stalls = 0; r_req = 1'b0; r_sel = 4'h0; r_we = 1'b0;
        r_addr = 32'h0; r_bwdata = 32'h0;
        mem_op_i = op; mem_addr_i = addr; mem_wdata_i = st;
        wd_i = 5'd7; wreg_i = wr; wdata_i = 32'h0BAD_0BAD;
        #1;
        while (stallreq_o && (r_stalls < 40)) begin
            r_stalls++;
            tick();
            bus_ack_i = 1'b0;
            if (bus_req_o) begin
                r_req = 1'b1; r_sel = bus_sel_o; r_we = bus_we_o;
                r_addr = bus_addr_o; r_bwdata = bus_wdata_o;
                if (w == waits) begin
                    bus_ack_i = 1'b1;
                    bus_rdata_i = rd;
                end
                w++;
            end
            #1;
        end
        r_req   = r_req | bus_req_o;
        r_res   = wdata_o;
        r_wreg  = wreg_o;
        r_llwe  = LLbit_we_o;
        r_llval = LLbit_value_o;
        r_adel  = excp_adel_o;
        r_ades  = excp_ades_o;
        tick();
        mem_op_i = MOP_NONE; wreg_i = 1'b0; bus_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; mem_op_i = MOP_LW; mem_addr_i = 32'h100;
        mem_wdata_i = 32'h0; wd_i = 5'd1; wreg_i = 1'b1; wdata_i = 32'h1234;
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
        bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        #2;
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_bus_req got %b exp 0", bus_req_o); end
        checks++; if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL reset_bus_addr got %h exp 0", bus_addr_o); end
        checks++; if (bus_sel_o !== 4'h0) begin errors++; $display("FAIL reset_bus_sel got %h exp 0", bus_sel_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stallreq_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got %b exp 0", wreg_o); end
        checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata_o); end
        mem_op_i = MOP_NONE; wreg_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        mem_op_i = MOP_NONE; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h0000_55AA;
        #1;
        checks++; if (wd_o !== 5'd3) begin errors++; $display("FAIL pass_wd got %0d exp 3", wd_o); end
        checks++; if (wreg_o !== 1'b1) begin errors++; $display("FAIL pass_wreg got %b exp 1", wreg_o); end
        checks++; if (wdata_o !== 32'h0000_55AA) begin errors++; $display("FAIL pass_wdata got %h exp 000055aa", wdata_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL pass_stall got %b exp 0", stallreq_o); end
        tick();
        wreg_i = 1'b0;
    endtask

    task automatic test_lw();
        run_op(MOP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
        checks++; if (r_sel !== 4'hF) begin errors++; $display("FAIL lw_sel got %h exp f", r_sel); end
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h exp 00000100", r_addr); end
        checks++; if (r_we !== 1'b0) begin errors++; $display("FAIL lw_we got %b exp 0", r_we); end
        checks++; if (r_stalls !== 2) begin errors++; $display("FAIL lw_stalls got %0d exp 2", r_stalls); end
        checks++; if (r_res !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", r_res); end
        checks++; if (r_wreg !== 1'b1) begin errors++; $display("FAIL lw_wreg got %b exp 1", r_wreg); end
    endtask

    task automatic test_byte_half_loads();
        run_op(MOP_LB, 32'h103, 32'h0, 32'h0000_00F0, 0, 1'b1);
        checks++; if (r_sel !== 4'b0001) begin errors++; $display("FAIL lb_sel got %b exp 0001", r_sel); end
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h exp 00000100", r_addr); end
        checks++; if (r_res !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data got %h exp fffffff0", r_res); end
        run_op(MOP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 1, 1'b1);
        checks++; if (r_res !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_data got %h exp 000000f0", r_res); end
        checks++; if (r_stalls !== 3) begin errors++; $display("FAIL lbu_stalls got %0d exp 3", r_stalls); end
        run_op(MOP_LH, 32'h000, 32'h0, 32'h8001_1234, 0, 1'b1);
        checks++; if (r_sel !== 4'b1100) begin errors++; $display("FAIL lh_sel got %b exp 1100", r_sel); end
        checks++; if (r_res !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", r_res); end
        run_op(MOP_LHU, 32'h002, 32'h0, 32'hAAAA_8001, 0, 1'b1);
        checks++; if (r_sel !== 4'b0011) begin errors++; $display("FAIL lhu_sel got %b exp 0011", r_sel); end
        checks++; if (r_res !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", r_res); end
    endtask

    task automatic test_stores();
        run_op(MOP_SB, 32'h102, 32'h0000_00AB, 32'h0, 0, 1'b0);
        checks++; if (r_sel !== 4'b0010) begin errors++; $display("FAIL sb_sel got %b exp 0010", r_sel); end
        checks++; if (r_bwdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", r_bwdata); end
        checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", r_we); end
        run_op(MOP_SH, 32'h002, 32'h5555_1234, 32'h0, 0, 1'b0);
        checks++; if (r_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel got %b exp 0011", r_sel); end
        checks++; if (r_bwdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata got %h exp 12341234", r_bwdata); end
    endtask

    task automatic test_ll_sc();
        run_op(MOP_LL, 32'h200, 32'h0, 32'h1234_5678, 0, 1'b1);
        checks++; if (r_res !== 32'h1234_5678) begin errors++; $display("FAIL ll_data got %h exp 12345678", r_res); end
        checks++; if (r_llwe !== 1'b1) begin errors++; $display("FAIL ll_llwe got %b exp 1", r_llwe); end
        checks++; if (r_llval !== 1'b1) begin errors++; $display("FAIL ll_llval got %b exp 1", r_llval); end
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
        run_op(MOP_SC, 32'h200, 32'hCAFE_F00D, 32'h0, 3, 1'b1);
        wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
        checks++; if (r_req !== 1'b1) begin errors++; $display("FAIL sc_req got %b exp 1", r_req); end
        checks++; if (r_we !== 1'b1) begin errors++; $display("FAIL sc_we got %b exp 1", r_we); end
        checks++; if (r_bwdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sc_wdata got %h exp cafef00d", r_bwdata); end
        checks++; if (r_stalls !== 5) begin errors++; $display("FAIL sc_stalls got %0d exp 5", r_stalls); end
        checks++; if (r_res !== 32'h1) begin errors++; $display("FAIL sc_result got %h exp 00000001", r_res); end
        checks++; if (r_llwe !== 1'b1) begin errors++; $display("FAIL sc_llwe got %b exp 1", r_llwe); end
        checks++; if (r_llval !== 1'b0) begin errors++; $display("FAIL sc_llval got %b exp 0", r_llval); end
    endtask

    task automatic test_sc_fail();
        LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
        run_op(MOP_SC, 32'h200, 32'hCAFE_F00D, 32'h0, 0, 1'b1);
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0;
        checks++; if (r_req !== 1'b0) begin errors++; $display("FAIL scf_req got %b exp 0", r_req); end
        checks++; if (r_stalls !== 0) begin errors++; $display("FAIL scf_stalls got %0d exp 0", r_stalls); end
        checks++; if (r_res !== 32'h0) begin errors++; $display("FAIL scf_result got %h exp 0", r_res); end
        checks++; if (r_wreg !== 1'b1) begin errors++; $display("FAIL scf_wreg got %b exp 1", r_wreg); end
        checks++; if (r_llwe !== 1'b0) begin errors++; $display("FAIL scf_llwe got %b exp 0", r_llwe); end
    endtask

    task automatic test_misaligned();
        run_op(MOP_SH, 32'h101, 32'h1234, 32'h0, 0, 1'b1);
        checks++; if (r_ades !== 1'b1) begin errors++; $display("FAIL sh_mis_ades got %b exp 1", r_ades); end
        checks++; if (r_req !== 1'b0) begin errors++; $display("FAIL sh_mis_req got %b exp 0", r_req); end
        checks++; if (r_wreg !== 1'b0) begin errors++; $display("FAIL sh_mis_wreg got %b exp 0", r_wreg); end
        run_op(MOP_LW, 32'h102, 32'h0, 32'h0, 0, 1'b1);
        checks++; if (r_adel !== 1'b1) begin errors++; $display("FAIL lw_mis_adel got %b exp 1", r_adel); end
        checks++; if (r_stalls !== 0) begin errors++; $display("FAIL lw_mis_stalls got %0d exp 0", r_stalls); end
        checks++; if (r_wreg !== 1'b0) begin errors++; $display("FAIL lw_mis_wreg got %b exp 0", r_wreg); end
    endtask

    task automatic test_flush();
        // flush while idle: nothing launched, outputs quiet
        mem_op_i = MOP_LW; mem_addr_i = 32'h100; wreg_i = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got %b exp 0", stallreq_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL flush_idle_wreg got %b exp 0", wreg_o); end
        tick();
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL flush_idle_req got %b exp 0", bus_req_o); end
        // flush while busy: abort, wait for the outstanding ack
        flush = 1'b0; mem_addr_i = 32'h300;
        tick();
        flush = 1'b1;
        #1;
        checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL flush_busy_req got %b exp 1", bus_req_o); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL abort1_stall got %b exp 1", stallreq_o); end
        checks++; if (wreg_o !== 1'b0) begin errors++; $display("FAIL abort1_wreg got %b exp 0", wreg_o); end
        checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL abort1_req got %b exp 1", bus_req_o); end
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
        #1;
        checks++; if (stallreq_o !== 1'b1) begin errors++; $display("FAIL abort2_stall got %b exp 1", stallreq_o); end
        checks++; if (LLbit_we_o !== 1'b0) begin errors++; $display("FAIL abort2_llwe got %b exp 0", LLbit_we_o); end
        tick();
        bus_ack_i = 1'b0; mem_op_i = MOP_NONE; wreg_i = 1'b0; wdata_i = 32'h0000_0042;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL abort_end_stall got %b exp 0", stallreq_o); end
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL abort_end_req got %b exp 0", bus_req_o); end
        checks++; if (wdata_o !== 32'h0000_0042) begin errors++; $display("FAIL abort_end_wdata got %h exp 00000042", wdata_o); end
        tick();
    endtask

    task automatic test_async_reset();
        mem_op_i = MOP_LW; mem_addr_i = 32'h400; wreg_i = 1'b1;
        tick();
        checks++; if (bus_req_o !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b exp 1", bus_req_o); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL rst_async_req got %b exp 0", bus_req_o); end
        checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_async_stall got %b exp 0", stallreq_o); end
        mem_op_i = MOP_NONE; wreg_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw();
        test_byte_half_loads();
        test_stores();
        test_ll_sc();
        test_sc_fail();
        test_misaligned();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
